// File: rtl/cra_diag_pkg.sv
// Shared types and encodings for the CRA diagnostic sequencer.
// Vectors are [N-1:0]; bit 0 of the MSB-first drawings is bit N-1 here.
package cra_diag_pkg;

  localparam int unsigned ADR_W  = 11;
  localparam int unsigned EBUS_W = 36;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned FLD_W  = 6;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_RD_ADR = 2'b01,
    OP_RD_LOC = 2'b10,
    OP_RD_SBR = 2'b11
  } cra_op_e;

  localparam logic [SEL_W-1:0] SEL_SBR_LO = 3'b010;
  localparam logic [SEL_W-1:0] SEL_ADR_LO = 3'b100;
  localparam logic [SEL_W-1:0] SEL_LOC_LO = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LD_LO,
    ST_LD_HI,
    ST_RD_LO,
    ST_RD_HI,
    ST_RESP
  } cra_state_e;

  typedef struct packed {
    logic [ADR_W-1:0] data;
    logic             parity;
    logic             err;
  } cra_rsp_t;

  // Low-half read select for a read op; the high half is this plus one.
  function automatic logic [SEL_W-1:0] lo_sel(input cra_op_e op);
    case (op)
      OP_RD_ADR: return SEL_ADR_LO;
      OP_RD_LOC: return SEL_LOC_LO;
      OP_RD_SBR: return SEL_SBR_LO;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/cra_diag_seq.sv
// CRA diagnostic sequencer: arbitrates for EBUS and runs the two-half
// dispatch-address load (051/052) or register read (14X) sequences.
module cra_diag_seq
  import cra_diag_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned GRANT_TIMEOUT = 63
) (
  input  logic              eboxClk,
  input  logic              eboxReset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [1:0]        cmdOp,
  input  logic [ADR_W-1:0]  cmdAdr,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [ADR_W-1:0]  rspData,
  output logic              rspParity,
  output logic              rspErr,
  output logic              ebusReq,
  input  logic              ebusGrant,
  output logic [EBUS_W-1:0] EBUS_OUT,
  output logic              diaFunc051,
  output logic              diaFunc052,
  output logic              diagReadFunc14X,
  output logic [SEL_W-1:0]  diagSel,
  input  logic [EBUS_W-1:0] CRA_EBUS
);

  cra_state_e        state_q, state_d;
  cra_op_e           op_q, op_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADR_W-1:0]  data_q, data_d;
  logic              par_q, par_d;
  logic              err_q, err_d;

  logic              rdy_d, vld_d, req_d, f051_d, f052_d, f14x_d;
  logic [SEL_W-1:0]  sel_d;
  logic [EBUS_W-1:0] ebus_d;
  cra_rsp_t          rsp_d;

  // Only the right-justified 6-bit field of the CRA readback is meaningful.
  logic unused_cra_hi;
  assign unused_cra_hi = ^CRA_EBUS[EBUS_W-1:FLD_W];

  // Next state, datapath and next registered output values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    par_d   = par_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (cmdValid && cmdReady) begin
          op_d    = cra_op_e'(cmdOp);
          adr_d   = cmdAdr;
          cnt_d   = '0;
          data_d  = '0;
          par_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        // A grant in the same cycle as the timeout wins.
        if (ebusGrant) begin
          cnt_d   = '0;
          state_d = (op_q == OP_LOAD) ? ST_LD_LO : ST_RD_LO;
        end else if (cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LD_LO: state_d = ST_LD_HI;
      ST_LD_HI: state_d = ST_RESP;
      ST_RD_LO: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          data_d[FLD_W-1:0] = CRA_EBUS[FLD_W-1:0];
          cnt_d             = '0;
          state_d           = ST_RD_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_HI: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          data_d[ADR_W-1:FLD_W] = CRA_EBUS[FLD_W-2:0];
          par_d                 = (op_q == OP_RD_ADR) && CRA_EBUS[FLD_W-1];
          cnt_d                 = '0;
          state_d               = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d  = (state_d == ST_IDLE);
    vld_d  = (state_d == ST_RESP);
    req_d  = (state_d == ST_ARB)   || (state_d == ST_LD_LO) || (state_d == ST_LD_HI) ||
             (state_d == ST_RD_LO) || (state_d == ST_RD_HI);
    f051_d = (state_d == ST_LD_LO);
    f052_d = (state_d == ST_LD_HI);
    f14x_d = (state_d == ST_RD_LO) || (state_d == ST_RD_HI);

    sel_d = '0;
    if (state_d == ST_RD_LO) sel_d = lo_sel(op_d);
    if (state_d == ST_RD_HI) sel_d = lo_sel(op_d) + SEL_W'(1);

    ebus_d = '0;
    if (state_d == ST_LD_LO) ebus_d[EBUS_W-1 -: FLD_W]       = adr_d[FLD_W-1:0];
    if (state_d == ST_LD_HI) ebus_d[EBUS_W-2 -: ADR_W-FLD_W] = adr_d[ADR_W-1:FLD_W];

    rsp_d = '0;
    if (vld_d) rsp_d = '{data: data_d, parity: par_d, err: err_d};
  end

  // State, datapath and output registers.
  always_ff @(posedge eboxClk) begin
    if (eboxReset) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_LOAD;
      adr_q           <= '0;
      cnt_q           <= '0;
      data_q          <= '0;
      par_q           <= 1'b0;
      err_q           <= 1'b0;
      cmdReady        <= 1'b1;
      rspValid        <= 1'b0;
      rspData         <= '0;
      rspParity       <= 1'b0;
      rspErr          <= 1'b0;
      ebusReq         <= 1'b0;
      EBUS_OUT        <= '0;
      diaFunc051      <= 1'b0;
      diaFunc052      <= 1'b0;
      diagReadFunc14X <= 1'b0;
      diagSel         <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      adr_q           <= adr_d;
      cnt_q           <= cnt_d;
      data_q          <= data_d;
      par_q           <= par_d;
      err_q           <= err_d;
      cmdReady        <= rdy_d;
      rspValid        <= vld_d;
      rspData         <= rsp_d.data;
      rspParity       <= rsp_d.parity;
      rspErr          <= rsp_d.err;
      ebusReq         <= req_d;
      EBUS_OUT        <= ebus_d;
      diaFunc051      <= f051_d;
      diaFunc052      <= f052_d;
      diagReadFunc14X <= f14x_d;
      diagSel         <= sel_d;
    end
  end

endmodule

// File: tb/tb_cra_diag_seq.sv
// Self-checking bench for cra_diag_seq: vector table plus corner sequences,
// responses checked against a scoreboard queue.
module tb_cra_diag_seq;

  localparam int S = 2;

  logic        eboxClk = 1'b0;
  logic        eboxReset;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [10:0] cmdAdr;
  logic        rspValid;
  logic        rspReady;
  logic [10:0] rspData;
  logic        rspParity;
  logic        rspErr;
  logic        ebusReq;
  logic        ebusGrant;
  logic [35:0] EBUS_OUT;
  logic        diaFunc051;
  logic        diaFunc052;
  logic        diagReadFunc14X;
  logic [2:0]  diagSel;
  logic [35:0] CRA_EBUS;

  logic [5:0]  cra_mem [8];

  typedef struct packed {
    logic [10:0] d;
    logic        p;
    logic        e;
  } rsp_t;

  typedef struct {
    logic [1:0]  op;
    logic [10:0] adr;
    int          gdly;
    logic [5:0]  lo;
    logic [5:0]  hi;
    logic [10:0] exp_data;
    logic        exp_par;
  } vec_t;

  rsp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  cra_diag_seq dut (
    .eboxClk(eboxClk), .eboxReset(eboxReset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdAdr(cmdAdr),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .rspParity(rspParity), .rspErr(rspErr),
    .ebusReq(ebusReq), .ebusGrant(ebusGrant), .EBUS_OUT(EBUS_OUT),
    .diaFunc051(diaFunc051), .diaFunc052(diaFunc052),
    .diagReadFunc14X(diagReadFunc14X), .diagSel(diagSel), .CRA_EBUS(CRA_EBUS)
  );

  always #5 eboxClk = ~eboxClk;

  // CRA model: upper junk bits must be ignored by the sequencer.
  assign CRA_EBUS = diagReadFunc14X ? {30'h2AAAAAAA, cra_mem[diagSel]} : 36'd0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge eboxClk) begin
    if (rspValid && rspReady) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h err %0b with nothing expected", rspData, rspErr);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_fields", 64'({rspData, rspParity, rspErr}), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge eboxClk);
    #1;
  endtask

  function automatic logic [2:0] sel_of(input logic [1:0] op);
    case (op)
      2'b01:   return 3'b100;
      2'b10:   return 3'b110;
      2'b11:   return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [10:0] adr);
    int n = 0;
    while (!cmdReady && n < 50) begin
      tick();
      n++;
    end
    check("issue_ready", 64'(cmdReady), 64'(1));
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdAdr   = adr;
    tick();
    cmdValid = 1'b0;
    check("accept_req_notready", 64'({ebusReq, cmdReady}), 64'(2'b10));
  endtask

  task automatic grant_after(input int n);
    for (int i = 0; i < n; i++) begin
      check("arb_wait", 64'({ebusReq, diaFunc051, diaFunc052, diagReadFunc14X}), 64'(4'b1000));
      tick();
    end
    ebusGrant = 1'b1;
    tick();
    ebusGrant = 1'b0;
  endtask

  // Entered at grant+1; returns in the first response cycle.
  task automatic expect_seq(input logic [1:0] op, input logic [10:0] adr);
    logic [2:0] sel;
    sel = sel_of(op);
    if (op == 2'b00) begin
      check("ld_lo", 64'({diaFunc051, diaFunc052, diagReadFunc14X, ebusReq, EBUS_OUT}),
            64'({1'b1, 1'b0, 1'b0, 1'b1, adr[5:0], 30'd0}));
      tick();
      check("ld_hi", 64'({diaFunc051, diaFunc052, diagReadFunc14X, ebusReq, EBUS_OUT}),
            64'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, adr[10:6], 30'd0}));
      tick();
    end else begin
      for (int k = 0; k < S; k++) begin
        check("rd_lo", 64'({diagReadFunc14X, diagSel, diaFunc051, diaFunc052, ebusReq, EBUS_OUT}),
              64'({1'b1, sel, 1'b0, 1'b0, 1'b1, 36'd0}));
        tick();
      end
      for (int k = 0; k < S; k++) begin
        check("rd_hi", 64'({diagReadFunc14X, diagSel, diaFunc051, diaFunc052, ebusReq, EBUS_OUT}),
              64'({1'b1, sel + 3'd1, 1'b0, 1'b0, 1'b1, 36'd0}));
        tick();
      end
    end
    check("rsp_cycle", 64'({rspValid, ebusReq, diagReadFunc14X, diaFunc051, diaFunc052, diagSel, EBUS_OUT}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 36'd0}));
  endtask

  task automatic finish_rsp();
    tick();
    check("post_rsp", 64'({cmdReady, rspValid, rspData, rspErr}), 64'({1'b1, 1'b0, 11'd0, 1'b0}));
  endtask

  task automatic run_vec(input vec_t v);
    cra_mem[sel_of(v.op)]         = v.lo;
    cra_mem[sel_of(v.op) + 3'd1]  = v.hi;
    sb.push_back('{d: v.exp_data, p: v.exp_par, e: 1'b0});
    issue(v.op, v.adr);
    grant_after(v.gdly);
    expect_seq(v.op, v.adr);
    finish_rsp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   n;
    logic seen;

    vecs[0] = '{2'b00, 11'o1777, 0, 6'o00, 6'o00, 11'o0000, 1'b0};
    vecs[1] = '{2'b10, 11'o0000, 0, 6'o25, 6'o03, 11'o0325, 1'b0};
    vecs[2] = '{2'b01, 11'o0000, 3, 6'o00, 6'o41, 11'o0100, 1'b1};
    vecs[3] = '{2'b11, 11'o0000, 1, 6'o52, 6'o77, 11'o3752, 1'b0};
    vecs[4] = '{2'b00, 11'o2345, 5, 6'o00, 6'o00, 11'o0000, 1'b0};
    vecs[5] = '{2'b01, 11'o0000, 0, 6'o17, 6'o25, 11'o2517, 1'b0};
    vecs[6] = '{2'b10, 11'o0000, 2, 6'o77, 6'o70, 11'o3077, 1'b0};

    for (int i = 0; i < 8; i++) cra_mem[i] = 6'o11;
    eboxReset = 1'b1;
    cmdValid  = 1'b0;
    cmdOp     = 2'b00;
    cmdAdr    = '0;
    rspReady  = 1'b1;
    ebusGrant = 1'b0;
    tick();
    check("reset_state", 64'({cmdReady, rspValid, rspData, rspParity, rspErr, ebusReq, EBUS_OUT,
                              diaFunc051, diaFunc052, diagReadFunc14X, diagSel}),
          64'({1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 36'd0, 1'b0, 1'b0, 1'b0, 3'd0}));
    tick();
    eboxReset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Grant never arrives.
    sb.push_back('{d: 11'd0, p: 1'b0, e: 1'b1});
    issue(2'b01, 11'd0);
    n    = 0;
    seen = 1'b0;
    while (ebusReq && n < 300) begin
      seen = seen | diaFunc051 | diaFunc052 | diagReadFunc14X;
      n++;
      tick();
    end
    check("timeout_req_cycles", 64'(n), 64'(63));
    check("timeout_no_strobes", 64'(seen), 64'(0));
    check("timeout_rsp", 64'({rspValid, rspErr, rspData}), 64'({1'b1, 1'b1, 11'd0}));
    finish_rsp();

    // Reset in RD_HI abandons the operation.
    cra_mem[3'b010] = 6'o12;
    cra_mem[3'b011] = 6'o34;
    issue(2'b11, 11'd0);
    grant_after(0);
    repeat (S) tick();
    check("in_rd_hi", 64'({diagReadFunc14X, diagSel, ebusReq}), 64'({1'b1, 3'b011, 1'b1}));
    eboxReset = 1'b1;
    tick();
    eboxReset = 1'b0;
    check("after_reset", 64'({cmdReady, rspValid, rspData, rspParity, rspErr, ebusReq, EBUS_OUT,
                              diaFunc051, diaFunc052, diagReadFunc14X, diagSel}),
          64'({1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 36'd0, 1'b0, 1'b0, 1'b0, 3'd0}));
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | rspValid | ebusReq;
    end
    check("no_rsp_after_reset", 64'(seen), 64'(0));
    run_vec(vecs[3]);

    // Response backpressure with a second command waiting.
    rspReady = 1'b0;
    cra_mem[3'b110] = 6'o25;
    cra_mem[3'b111] = 6'o03;
    sb.push_back('{d: 11'o0325, p: 1'b0, e: 1'b0});
    issue(2'b10, 11'd0);
    grant_after(0);
    expect_seq(2'b10, 11'd0);
    cmdValid = 1'b1;
    cmdOp    = 2'b00;
    cmdAdr   = 11'o0001;
    for (int k = 0; k < 10; k++) begin
      check("bp_hold", 64'({rspValid, rspData, cmdReady, ebusReq}), 64'({1'b1, 11'o0325, 1'b0, 1'b0}));
      tick();
    end
    rspReady = 1'b1;
    tick();
    check("bp_after_hs", 64'({cmdReady, rspValid, ebusReq}), 64'(3'b100));
    sb.push_back('{d: 11'd0, p: 1'b0, e: 1'b0});
    tick();
    cmdValid = 1'b0;
    check("bp_second_accept", 64'({ebusReq, cmdReady}), 64'(2'b10));
    grant_after(0);
    expect_seq(2'b00, 11'o0001);
    finish_rsp();

    tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
